// File: rtl/issue_ctrl_pkg.sv
// Shared types for the dual-issue stage.
//   optype_t     : coarse functional-unit class of an instruction
//   issue_inst_t : instruction payload as presented by the instruction buffer
//   helpers      : is_load / is_long_lat / uses_r2 classify a payload
package issue_ctrl_pkg;

   localparam int REG_W     = 5;
   localparam int NUM_REGS  = 32;
   localparam int NUM_SLOTS = 2;
   localparam int NUM_RD    = 2 * NUM_SLOTS;

   typedef enum logic [2:0] {
      ALU   = 3'd0,
      MEM   = 3'd1,
      MUL   = 3'd2,
      DIV   = 3'd3,
      BR    = 3'd4,
      CSR   = 3'd5,
      OTHER = 3'd6
   } optype_t;

   // Field order mirrors the buffer payload.
   typedef struct packed {
      logic [31:0]      pc;
      optype_t          optype;
      logic [7:0]       opcode;
      logic             is_store;      // MEM only: store (r2 carries store data)
      logic [REG_W-1:0] dest;
      logic [31:0]      imm;
      logic [REG_W-1:0] r1;
      logic [REG_W-1:0] r2;
      logic             src2_is_imm;
      logic             br_pred_taken;
      logic [31:0]      br_target;
      logic             have_excp;
      logic [5:0]       excp_code;
      logic [11:0]      csr_addr;
      logic             csr_we;
      logic             is_spec_op;
   } issue_inst_t;

   function automatic logic is_load(issue_inst_t x);
      return (x.optype == MEM) && !x.is_store;
   endfunction

   // Results the bypass network cannot cover; these go through the scoreboard.
   function automatic logic is_long_lat(issue_inst_t x);
      return is_load(x) || (x.optype == MUL) || (x.optype == DIV);
   endfunction

   // A store reads r2 as data even though its second ALU operand is the offset.
   function automatic logic uses_r2(issue_inst_t x);
      return !x.src2_is_imm || ((x.optype == MEM) && x.is_store);
   endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Busy scoreboard for long-latency destinations.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : clears every busy bit at the next edge
//   set_en/dest : one set port per issue slot
//   clr_en/dest : NUM_WB writeback clear ports
//   rd_addr     : read addresses (a.r1, a.r2, b.r1, b.r2)
//   rd_busy     : busy bit per read port (r0 always reads not-busy)
module issue_scoreboard
   import issue_ctrl_pkg::*;
#(
   parameter int NUM_WB = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush,
   input  logic [NUM_SLOTS-1:0]              set_en,
   input  logic [NUM_SLOTS-1:0][REG_W-1:0]   set_dest,
   input  logic [NUM_WB-1:0]                 clr_en,
   input  logic [NUM_WB-1:0][REG_W-1:0]      clr_dest,
   input  logic [NUM_RD-1:0][REG_W-1:0]      rd_addr,
   output logic [NUM_RD-1:0]                 rd_busy
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int s = 0; s < NUM_SLOTS; s++)
         if (set_en[s]) set_mask[set_dest[s]] = 1'b1;
      for (int w = 0; w < NUM_WB; w++)
         if (clr_en[w]) clr_mask[clr_dest[w]] = 1'b1;
      set_mask[0] = 1'b0;   // r0 is hardwired zero, never pending
   end

   // Set is applied after clear so a same-cycle set/clear leaves the bit busy:
   // the clearing writeback belongs to an older producer.
   always_ff @(posedge clk) begin
      if (reset || flush) busy <= '0;
      else                busy <= (busy & ~clr_mask) | set_mask;
   end

   // No writeback bypass: a cleared register is readable the cycle after.
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      assign rd_busy[g] = (rd_addr[g] != '0) && busy[rd_addr[g]];
   end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue stage behind the instruction buffer.
//   clk, reset          : clock, synchronous active-high reset
//   flush               : pipeline flush (kills issue, clears outputs and scoreboard)
//   a_valid/a_inst      : buffer head slot (older)
//   b_valid/b_inst      : buffer second slot (younger)
//   issue_size          : slots consumed this cycle (0..2), combinational
//   rr_allowin          : register-read stage can accept a pair
//   wb_valid/wb_dest    : long-latency writebacks clearing busy bits
//   o_a_*/o_b_*         : registered issued pair
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int NUM_WB = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         a_valid,
   input  issue_inst_t                  a_inst,
   input  logic                         b_valid,
   input  issue_inst_t                  b_inst,
   output logic [1:0]                   issue_size,
   input  logic                         rr_allowin,
   input  logic [NUM_WB-1:0]            wb_valid,
   input  logic [NUM_WB-1:0][REG_W-1:0] wb_dest,
   output logic                         o_a_valid,
   output issue_inst_t                  o_a_inst,
   output logic                         o_b_valid,
   output issue_inst_t                  o_b_inst
);

   issue_inst_t [NUM_SLOTS-1:0]            slot;
   logic        [NUM_SLOTS-1:0]            src_busy;
   logic        [NUM_SLOTS-1:0]            issue;
   logic        [NUM_SLOTS-1:0]            set_en;
   logic        [NUM_SLOTS-1:0][REG_W-1:0] set_dest;
   logic        [NUM_RD-1:0][REG_W-1:0]    rd_addr;
   logic        [NUM_RD-1:0]               rd_busy;
   logic                                   pair_block;
   logic                                   raw_pair;

   assign slot[0] = a_inst;
   assign slot[1] = b_inst;

   // Per-slot operand lookup and scoreboard set request.
   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      assign rd_addr[2*g]   = slot[g].r1;
      assign rd_addr[2*g+1] = slot[g].r2;
      assign src_busy[g]    = rd_busy[2*g] || (uses_r2(slot[g]) && rd_busy[2*g+1]);
      assign set_en[g]      = issue[g] && is_long_lat(slot[g]);
      assign set_dest[g]    = slot[g].dest;
   end

   issue_scoreboard #(.NUM_WB(NUM_WB)) u_sb (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .set_en   (set_en),
      .set_dest (set_dest),
      .clr_en   (wb_valid),
      .clr_dest (wb_dest),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy)
   );

   // Intra-pair dependence: b would read or overwrite a's result in the same
   // register-read cycle, which neither the scoreboard nor bypass can resolve.
   assign raw_pair = (a_inst.dest != '0) &&
                     ((a_inst.dest == b_inst.r1) ||
                      (uses_r2(b_inst) && (a_inst.dest == b_inst.r2)));

   always_comb begin
      pair_block = 1'b0;
      // a redirects or serialises: nothing may travel beside it
      if ((a_inst.optype == BR) || (a_inst.optype == CSR) ||
          a_inst.is_spec_op || a_inst.have_excp)
         pair_block = 1'b1;
      // b must be the oldest in flight for these
      if ((b_inst.optype == CSR) || b_inst.is_spec_op || b_inst.have_excp)
         pair_block = 1'b1;
      // single memory port, single mul/div unit
      if ((a_inst.optype == MEM) && (b_inst.optype == MEM))
         pair_block = 1'b1;
      if (((a_inst.optype == MUL) || (a_inst.optype == DIV)) &&
          ((b_inst.optype == MUL) || (b_inst.optype == DIV)))
         pair_block = 1'b1;
      if (raw_pair)
         pair_block = 1'b1;
      if ((a_inst.dest != '0) && (a_inst.dest == b_inst.dest))
         pair_block = 1'b1;
   end

   // In-order: b only ever rides along with a.
   assign issue[0]   = a_valid && rr_allowin && !flush && !reset && !src_busy[0];
   assign issue[1]   = issue[0] && b_valid && !src_busy[1] && !pair_block;
   assign issue_size = {1'b0, issue[0]} + {1'b0, issue[1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         o_a_valid <= 1'b0;
         o_b_valid <= 1'b0;
         o_a_inst  <= '0;
         o_b_inst  <= '0;
      end else if (flush) begin
         o_a_valid <= 1'b0;
         o_b_valid <= 1'b0;
      end else if (rr_allowin) begin
         o_a_valid <= issue[0];
         o_b_valid <= issue[1];
         o_a_inst  <= a_inst;
         o_b_inst  <= b_inst;
      end
   end

   // The buffer fills from the head; a younger slot without an older one is a bug upstream.
   a_b_order : assert property (@(posedge clk) disable iff (reset) !(!a_valid && b_valid));

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
   import issue_ctrl_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  flush;
   logic                  a_valid;
   issue_inst_t           a_inst;
   logic                  b_valid;
   issue_inst_t           b_inst;
   logic [1:0]            issue_size;
   logic                  rr_allowin;
   logic [1:0]            wb_valid;
   logic [1:0][REG_W-1:0] wb_dest;
   logic                  o_a_valid;
   issue_inst_t           o_a_inst;
   logic                  o_b_valid;
   issue_inst_t           o_b_inst;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   issue_ctrl #(.NUM_WB(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .a_valid    (a_valid),
      .a_inst     (a_inst),
      .b_valid    (b_valid),
      .b_inst     (b_inst),
      .issue_size (issue_size),
      .rr_allowin (rr_allowin),
      .wb_valid   (wb_valid),
      .wb_dest    (wb_dest),
      .o_a_valid  (o_a_valid),
      .o_a_inst   (o_a_inst),
      .o_b_valid  (o_b_valid),
      .o_b_inst   (o_b_inst)
   );

   function automatic issue_inst_t mk(optype_t op, logic st, logic [4:0] d,
                                      logic [4:0] r1, logic [4:0] r2, logic imm);
      issue_inst_t x;
      x             = '0;
      x.pc          = 32'h1000 + {$urandom_range(0, 255), 2'b00};
      x.optype      = op;
      x.opcode      = 8'(op) + 8'h30;
      x.is_store    = st;
      x.dest        = d;
      x.imm         = 32'h10;
      x.r1          = r1;
      x.r2          = r2;
      x.src2_is_imm = imm;
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(issue_inst_t a, logic av, issue_inst_t b, logic bv);
      a_inst  = a;
      a_valid = av;
      b_inst  = b;
      b_valid = bv;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      flush      = 1'b0;
      rr_allowin = 1'b1;
      wb_valid   = '0;
      wb_dest    = '0;
      drive('0, 1'b0, '0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      issue_inst_t a, b;
      a = mk(ALU, 0, 5, 1, 2, 0);
      b = mk(ALU, 0, 8, 6, 0, 1);
      reset = 1'b1; flush = 1'b0; rr_allowin = 1'b1; wb_valid = '0; wb_dest = '0;
      drive(a, 1'b1, b, 1'b1);
      #1;
      checks++;
      if (issue_size !== 2'd0) begin errors++; $display("FAIL reset_size: got %0d expected 0", issue_size); end
      tick();
      checks++;
      if (o_a_valid !== 1'b0 || o_b_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got a=%b b=%b expected 0 0", o_a_valid, o_b_valid);
      end
      checks++;
      if (o_a_inst !== '0 || o_b_inst !== '0) begin
         errors++; $display("FAIL reset_inst: got a=%h expected 0", o_a_inst);
      end
      reset = 1'b0;
      drive('0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_alu_pair();
      issue_inst_t a, b;
      do_reset();
      a = mk(ALU, 0, 5, 1, 2, 0);
      b = mk(ALU, 0, 8, 6, 0, 1);
      drive(a, 1'b1, b, 1'b1);
      #1;
      checks++;
      if (issue_size !== 2'd2) begin errors++; $display("FAIL alu_pair_size: got %0d expected 2", issue_size); end
      tick();
      checks++;
      if (o_a_valid !== 1'b1 || o_b_valid !== 1'b1) begin
         errors++; $display("FAIL alu_pair_valid: got a=%b b=%b expected 1 1", o_a_valid, o_b_valid);
      end
      checks++;
      if (o_a_inst !== a || o_b_inst !== b) begin
         errors++; $display("FAIL alu_pair_inst: got a=%h expected %h", o_a_inst, a);
      end
      // empty buffer loads a bubble
      drive('0, 1'b0, '0, 1'b0);
      #1;
      checks++;
      if (issue_size !== 2'd0) begin errors++; $display("FAIL empty_size: got %0d expected 0", issue_size); end
      tick();
      checks++;
      if (o_a_valid !== 1'b0 || o_b_valid !== 1'b0) begin
         errors++; $display("FAIL empty_valid: got a=%b b=%b expected 0 0", o_a_valid, o_b_valid);
      end
   endtask

   task automatic test_raw();
      issue_inst_t a, b;
      do_reset();
      a = mk(ALU, 0, 5, 1, 2, 0);
      b = mk(ALU, 0, 9, 5, 3, 0);
      drive(a, 1'b1, b, 1'b1);
      #1;
      checks++;
      if (issue_size !== 2'd1) begin errors++; $display("FAIL raw_size: got %0d expected 1", issue_size); end
      tick();
      checks++;
      if (o_a_valid !== 1'b1 || o_b_valid !== 1'b0) begin
         errors++; $display("FAIL raw_valid: got a=%b b=%b expected 1 0", o_a_valid, o_b_valid);
      end
      drive(b, 1'b1, '0, 1'b0);
      #1;
      checks++;
      if (issue_size !== 2'd1) begin errors++; $display("FAIL raw_b_alone: got %0d expected 1", issue_size); end
      tick();
      checks++;
      if (o_a_inst !== b || o_a_valid !== 1'b1) begin
         errors++; $display("FAIL raw_b_out: got v=%b inst=%h expected 1 %h", o_a_valid, o_a_inst, b);
      end
   endtask

   task automatic test_pair_restrict();
      issue_inst_t ta[12];
      issue_inst_t tb[12];
      int          te[12];
      ta[0]  = mk(BR,  0, 0, 1, 2, 0);  tb[0]  = mk(ALU, 0, 3, 4, 5, 0);  te[0]  = 1;
      ta[1]  = mk(ALU, 0, 3, 1, 0, 1);  tb[1]  = mk(CSR, 0, 4, 1, 0, 1);  te[1]  = 1;
      ta[2]  = mk(MEM, 0, 3, 1, 0, 1);  tb[2]  = mk(MEM, 1, 0, 2, 6, 1);  te[2]  = 1;
      ta[3]  = mk(MUL, 0, 3, 1, 2, 0);  tb[3]  = mk(DIV, 0, 4, 5, 6, 0);  te[3]  = 1;
      ta[4]  = mk(ALU, 0, 3, 1, 2, 0);  tb[4]  = mk(ALU, 0, 3, 1, 0, 1);  te[4]  = 1;
      ta[5]  = mk(ALU, 0, 3, 1, 2, 0);  tb[5]  = mk(ALU, 0, 4, 1, 3, 1);  te[5]  = 2;
      ta[6]  = mk(ALU, 0, 3, 1, 2, 0);  tb[6]  = mk(MEM, 1, 0, 1, 3, 1);  te[6]  = 1;
      ta[7]  = mk(ALU, 0, 0, 1, 2, 0);  tb[7]  = mk(ALU, 0, 0, 0, 0, 0);  te[7]  = 2;
      ta[8]  = mk(ALU, 0, 3, 1, 2, 0);  tb[8]  = mk(ALU, 0, 4, 5, 6, 0);  te[8]  = 1;
      ta[8].is_spec_op = 1'b1;
      ta[9]  = mk(ALU, 0, 3, 1, 2, 0);  tb[9]  = mk(ALU, 0, 4, 5, 6, 0);  te[9]  = 1;
      tb[9].have_excp = 1'b1;
      ta[10] = mk(MEM, 0, 3, 1, 0, 1);  tb[10] = mk(MUL, 0, 4, 1, 2, 0);  te[10] = 2;
      ta[11] = mk(ALU, 0, 3, 1, 2, 0);  tb[11] = mk(ALU, 0, 4, 3, 0, 1);  te[11] = 1;
      for (int i = 0; i < 12; i++) begin
         do_reset();
         drive(ta[i], 1'b1, tb[i], 1'b1);
         #1;
         checks++;
         if (issue_size !== 2'(te[i])) begin
            errors++; $display("FAIL pair_case_%0d: got %0d expected %0d", i, issue_size, te[i]);
         end
      end
   endtask

   task automatic test_load_use();
      issue_inst_t ld, rd;
      do_reset();
      ld = mk(MEM, 0, 7, 1, 0, 1);
      rd = mk(ALU, 0, 8, 7, 0, 1);
      drive(ld, 1'b1, '0, 1'b0);
      #1;
      checks++;
      if (issue_size !== 2'd1) begin errors++; $display("FAIL load_issue: got %0d expected 1", issue_size); end
      tick();
      drive(rd, 1'b1, '0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (issue_size !== 2'd0) begin errors++; $display("FAIL load_use_stall_%0d: got %0d expected 0", i, issue_size); end
         tick();
      end
      wb_valid   = 2'b01;
      wb_dest[0] = 5'd7;
      #1;
      checks++;
      if (issue_size !== 2'd0) begin errors++; $display("FAIL load_use_wb_cycle: got %0d expected 0", issue_size); end
      tick();
      wb_valid = '0;
      #1;
      checks++;
      if (issue_size !== 2'd1) begin errors++; $display("FAIL load_use_after_wb: got %0d expected 1", issue_size); end
      tick();
      checks++;
      if (o_a_valid !== 1'b1 || o_a_inst !== rd) begin
         errors++; $display("FAIL load_use_out: got v=%b inst=%h expected 1 %h", o_a_valid, o_a_inst, rd);
      end
   endtask

   task automatic test_set_wins();
      issue_inst_t ld, rd, ld0, rd0, st, alu;
      do_reset();
      ld  = mk(MEM, 0, 7, 1, 0, 1);
      rd  = mk(ALU, 0, 8, 7, 0, 1);
      ld0 = mk(MEM, 0, 0, 1, 0, 1);
      rd0 = mk(ALU, 0, 9, 0, 0, 0);
      st  = mk(MEM, 1, 0, 1, 7, 1);
      alu = mk(ALU, 0, 4, 1, 7, 1);
      drive(ld, 1'b1, '0, 1'b0);
      wb_valid   = 2'b10;
      wb_dest[1] = 5'd7;
      tick();
      wb_valid = '0;
      drive(rd, 1'b1, '0, 1'b0);
      #1;
      checks++;
      if (issue_size !== 2'd0) begin errors++; $display("FAIL set_wins: got %0d expected 0", issue_size); end
      drive(ld0, 1'b1, '0, 1'b0);
      tick();
      drive(rd0, 1'b1, '0, 1'b0);
      #1;
      checks++;
      if (issue_size !== 2'd1) begin errors++; $display("FAIL r0_never_busy: got %0d expected 1", issue_size); end
      drive(st, 1'b1, '0, 1'b0);
      #1;
      checks++;
      if (issue_size !== 2'd0) begin errors++; $display("FAIL store_data_busy: got %0d expected 0", issue_size); end
      drive(alu, 1'b1, '0, 1'b0);
      #1;
      checks++;
      if (issue_size !== 2'd1) begin errors++; $display("FAIL imm_ignores_r2: got %0d expected 1", issue_size); end
   endtask

   task automatic test_stall();
      issue_inst_t xa, xb, ya, yb;
      do_reset();
      xa = mk(ALU, 0, 1, 2, 3, 0);
      xb = mk(ALU, 0, 4, 5, 6, 0);
      ya = mk(ALU, 0, 10, 11, 12, 0);
      yb = mk(ALU, 0, 13, 14, 0, 1);
      drive(xa, 1'b1, xb, 1'b1);
      tick();
      drive(ya, 1'b1, yb, 1'b1);
      rr_allowin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (issue_size !== 2'd0) begin errors++; $display("FAIL stall_size_%0d: got %0d expected 0", i, issue_size); end
         tick();
         checks++;
         if (o_a_inst !== xa || o_b_inst !== xb || o_a_valid !== 1'b1 || o_b_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold_%0d: got a=%h expected %h", i, o_a_inst, xa);
         end
      end
      rr_allowin = 1'b1;
      #1;
      checks++;
      if (issue_size !== 2'd2) begin errors++; $display("FAIL stall_release: got %0d expected 2", issue_size); end
      tick();
      checks++;
      if (o_a_inst !== ya || o_b_inst !== yb || o_b_valid !== 1'b1) begin
         errors++; $display("FAIL stall_release_out: got b=%h expected %h", o_b_inst, yb);
      end
   endtask

   task automatic test_flush();
      issue_inst_t ld, mu, r3, r9;
      do_reset();
      ld = mk(MEM, 0, 3, 1, 0, 1);
      mu = mk(MUL, 0, 9, 1, 2, 0);
      r3 = mk(ALU, 0, 11, 3, 0, 1);
      r9 = mk(ALU, 0, 12, 9, 0, 1);
      drive(ld, 1'b1, mu, 1'b1);
      #1;
      checks++;
      if (issue_size !== 2'd2) begin errors++; $display("FAIL flush_setup: got %0d expected 2", issue_size); end
      tick();
      drive(r3, 1'b1, r9, 1'b1);
      #1;
      checks++;
      if (issue_size !== 2'd0) begin errors++; $display("FAIL flush_busy_pre: got %0d expected 0", issue_size); end
      flush = 1'b1;
      #1;
      checks++;
      if (issue_size !== 2'd0) begin errors++; $display("FAIL flush_size: got %0d expected 0", issue_size); end
      tick();
      flush = 1'b0;
      checks++;
      if (o_a_valid !== 1'b0 || o_b_valid !== 1'b0) begin
         errors++; $display("FAIL flush_valid: got a=%b b=%b expected 0 0", o_a_valid, o_b_valid);
      end
      #1;
      checks++;
      if (issue_size !== 2'd2) begin errors++; $display("FAIL flush_sb_clear: got %0d expected 2", issue_size); end
      tick();
      checks++;
      if (o_a_valid !== 1'b1 || o_a_inst !== r3) begin
         errors++; $display("FAIL flush_reissue: got v=%b inst=%h expected 1 %h", o_a_valid, o_a_inst, r3);
      end
   endtask

   initial begin
      test_reset();
      test_alu_pair();
      test_raw();
      test_pair_restrict();
      test_load_use();
      test_set_wins();
      test_stall();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
